// File: rtl/jk_ff_checker.sv
// ---------------------------------------------------------------------------
// jk_ff_checker
//   Synthesizable monitor that sits beside a clocked JK flip-flop (whatever
//   its internal construction), runs a golden JK model in lock-step and
//   reports mismatches, check/error counts and JK-mode coverage.
//
// Ports
//   clk            in   rising-edge clock shared with the observed flop
//   rst            in   asynchronous active-high reset
//   en             in   1 = checking enabled, 0 = fall back to IDLE
//   J, K           in   inputs as driven into the observed flop
//   Q, Q_bar       in   outputs of the observed flop
//   err            out  sticky mismatch flag
//   err_pulse      out  one cycle high per mismatching compare
//   check_count    out  compared cycles (saturating)
//   err_count      out  mismatching cycles (saturating)
//   first_err_idx  out  check_count value at the first mismatch
//   mode_seen      out  coverage {toggle, set, reset, hold}
//   state          out  0 IDLE, 1 SYNC, 2 CHECK, 3 FAIL
// ---------------------------------------------------------------------------
module jk_ff_checker #(
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             J,
  input  logic             K,
  input  logic             Q,
  input  logic             Q_bar,
  output logic             err,
  output logic             err_pulse,
  output logic [CNT_W-1:0] check_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [3:0]       mode_seen,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2,
    ST_FAIL  = 2'd3
  } state_t;

  state_t state_r;
  state_t state_nxt_s;
  logic   exp_q_r;
  logic   cmp_s;
  logic   mismatch_s;

  // Golden JK next-state function.
  function automatic logic jk_next(input logic j, input logic k, input logic q);
    logic r;
    case ({j, k})
      2'b00:   r = q;
      2'b01:   r = 1'b0;
      2'b10:   r = 1'b1;
      2'b11:   r = ~q;
      default: r = q;
    endcase
    return r;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  // A compare happens only on CHECK edges with checking still enabled.
  assign cmp_s      = (state_r == ST_CHECK) && en;
  // Q_bar must be the complement of Q; Q must match the golden model.
  assign mismatch_s = (Q != exp_q_r) | (Q_bar == Q);
  assign state      = state_r;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; FAIL is left only through reset.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (en) begin
          state_nxt_s = ST_SYNC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SYNC: begin
        if (en) begin
          state_nxt_s = ST_CHECK;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (!en) begin
          state_nxt_s = ST_IDLE;
        end else if (mismatch_s && STOP_ON_ERR) begin
          state_nxt_s = ST_FAIL;
        end else begin
          state_nxt_s = ST_CHECK;
        end
      end
      ST_FAIL: begin
        state_nxt_s = ST_FAIL;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Golden model, counters, coverage and error reporting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q_r       <= 1'b0;
      err           <= 1'b0;
      err_pulse     <= 1'b0;
      check_count   <= {CNT_W{1'b0}};
      err_count     <= {CNT_W{1'b0}};
      first_err_idx <= {CNT_W{1'b0}};
      mode_seen     <= 4'b0000;
    end else begin
      err_pulse <= 1'b0;
      if ((state_r == ST_SYNC) && en) begin
        // Seed from the observed Q so the model starts aligned with the flop.
        exp_q_r <= jk_next(J, K, Q);
      end else if (cmp_s) begin
        exp_q_r              <= jk_next(J, K, exp_q_r);
        mode_seen[{J, K}]    <= 1'b1;
        check_count          <= sat_inc(check_count);
        if (mismatch_s) begin
          err_count <= sat_inc(err_count);
          err_pulse <= 1'b1;
          err       <= 1'b1;
          if (!err) begin
            first_err_idx <= check_count;
          end else begin
            first_err_idx <= first_err_idx;
          end
        end else begin
          err_count <= err_count;
        end
      end else begin
        exp_q_r <= exp_q_r;
      end
    end
  end

endmodule

// File: tb/tb_jk_ff_checker.sv
// ---------------------------------------------------------------------------
// tb_jk_ff_checker
//   Drives a behavioural JK flop (with fault injection) into two checker
//   instances: u0 (CNT_W=16, stop on error) and u1 (CNT_W=3, keep going).
//   A behavioural model predicts every output; a compare process checks it
//   each falling edge, and literal checks pin key points of the scenario.
// ---------------------------------------------------------------------------
module tb_jk_ff_checker;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic j_s, k_s;
  logic fq;
  logic force_q0, qb_stuck;
  logic q_s, qb_s;

  logic        o0_err, o0_pulse;
  logic [15:0] o0_cc, o0_ec, o0_fe;
  logic [3:0]  o0_ms;
  logic [1:0]  o0_st;
  logic        o1_err, o1_pulse;
  logic [2:0]  o1_cc, o1_ec, o1_fe;
  logic [3:0]  o1_ms;
  logic [1:0]  o1_st;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state per instance.
  int       m_st[2];
  bit       m_exp[2];
  int       m_chk[2];
  int       m_errc[2];
  int       m_first[2];
  bit       m_err[2];
  bit       m_pulse[2];
  bit [3:0] m_seen[2];
  int       m_max[2]  = '{65535, 7};
  bit       m_stop[2] = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  assign q_s  = force_q0 ? 1'b0 : fq;
  assign qb_s = qb_stuck ? 1'b0 : ~fq;

  jk_ff_checker #(.CNT_W(16), .STOP_ON_ERR(1'b1)) u0 (
    .clk(clk), .rst(rst), .en(en), .J(j_s), .K(k_s), .Q(q_s), .Q_bar(qb_s),
    .err(o0_err), .err_pulse(o0_pulse), .check_count(o0_cc), .err_count(o0_ec),
    .first_err_idx(o0_fe), .mode_seen(o0_ms), .state(o0_st)
  );

  jk_ff_checker #(.CNT_W(3), .STOP_ON_ERR(1'b0)) u1 (
    .clk(clk), .rst(rst), .en(en), .J(j_s), .K(k_s), .Q(q_s), .Q_bar(qb_s),
    .err(o1_err), .err_pulse(o1_pulse), .check_count(o1_cc), .err_count(o1_ec),
    .first_err_idx(o1_fe), .mode_seen(o1_ms), .state(o1_st)
  );

  // J sets, K resets, both toggle, neither holds.
  function automatic bit golden(input bit j, input bit k, input bit q);
    if (j && k) return !q;
    if (j)      return 1'b1;
    if (k)      return 1'b0;
    return q;
  endfunction

  function automatic bit bad(input int i);
    return (q_s !== m_exp[i]) || (qb_s !== !q_s);
  endfunction

  function automatic int sat(input int v, input int i);
    return (v > m_max[i]) ? m_max[i] : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Observed flop plus the behavioural checker model, both on the rising edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_st[i] <= 0; m_exp[i] <= 1'b0; m_chk[i] <= 0; m_errc[i] <= 0;
        m_first[i] <= 0; m_err[i] <= 1'b0; m_pulse[i] <= 1'b0; m_seen[i] <= 4'b0000;
      end
    end else begin
      fq <= golden(j_s, k_s, fq);
      for (int i = 0; i < 2; i++) begin
        m_pulse[i] <= 1'b0;
        case (m_st[i])
          0: m_st[i] <= en ? 1 : 0;
          1: begin
            if (en) begin
              m_exp[i] <= golden(j_s, k_s, q_s);
              m_st[i]  <= 2;
            end else begin
              m_st[i] <= 0;
            end
          end
          2: begin
            if (!en) begin
              m_st[i] <= 0;
            end else begin
              m_chk[i]  <= m_chk[i] + 1;
              m_seen[i] <= m_seen[i] | (4'b0001 << (2 * int'(j_s) + int'(k_s)));
              m_exp[i]  <= golden(j_s, k_s, m_exp[i]);
              if (bad(i)) begin
                m_errc[i]  <= m_errc[i] + 1;
                m_pulse[i] <= 1'b1;
                m_err[i]   <= 1'b1;
                if (!m_err[i]) m_first[i] <= m_chk[i];
                if (m_stop[i]) m_st[i] <= 3;
              end
            end
          end
          default: m_st[i] <= m_st[i];
        endcase
      end
    end
  end

  // Compare process: every falling edge outside reset, both instances.
  always @(negedge clk) begin
    if (!rst) begin
      chk("u0.state", o0_st, m_st[0]);
      chk("u0.err", o0_err, m_err[0]);
      chk("u0.err_pulse", o0_pulse, m_pulse[0]);
      chk("u0.check_count", o0_cc, sat(m_chk[0], 0));
      chk("u0.err_count", o0_ec, sat(m_errc[0], 0));
      chk("u0.first_err_idx", o0_fe, sat(m_first[0], 0));
      chk("u0.mode_seen", o0_ms, m_seen[0]);
      chk("u1.state", o1_st, m_st[1]);
      chk("u1.err", o1_err, m_err[1]);
      chk("u1.err_pulse", o1_pulse, m_pulse[1]);
      chk("u1.check_count", o1_cc, sat(m_chk[1], 1));
      chk("u1.err_count", o1_ec, sat(m_errc[1], 1));
      chk("u1.first_err_idx", o1_fe, sat(m_first[1], 1));
      chk("u1.mode_seen", o1_ms, m_seen[1]);
    end
  end

  // Drive J/K just after a falling edge, then wait for the next one.
  task automatic step(input bit j, input bit k);
    j_s = j;
    k_s = k;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; j_s = 1'b0; k_s = 1'b0;
    force_q0 = 1'b0; qb_stuck = 1'b0;

    // Reset state before the first edge.
    #3;
    chk("rst.state", o0_st, 32'd0);
    chk("rst.err", o0_err, 32'd0);
    chk("rst.err_pulse", o0_pulse, 32'd0);
    chk("rst.check_count", o0_cc, 32'd0);
    chk("rst.mode_seen", o0_ms, 32'd0);

    @(negedge clk); #1;
    rst = 1'b0; en = 1'b1;

    // Clean run: IDLE edge, SYNC edge, then 6 CHECK edges covering all modes.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b1, 1'b0);
    step(1'b0, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b1);
    chk("clean.check_count", o0_cc, 32'd6);
    chk("clean.err", o0_err, 32'd0);
    chk("clean.err_count", o0_ec, 32'd0);
    chk("clean.mode_seen", o0_ms, 32'd15);
    chk("clean.state", o0_st, 32'd2);

    // en drop for 3 cycles while the flop keeps toggling.
    en = 1'b0;
    step(1'b1, 1'b1);
    chk("endrop.state", o0_st, 32'd0);
    step(1'b1, 1'b1); step(1'b1, 1'b1);
    chk("endrop.hold_count", o0_cc, 32'd6);
    en = 1'b1;
    step(1'b1, 1'b1);
    chk("reenter.sync", o0_st, 32'd1);
    step(1'b0, 1'b0);
    chk("reenter.check", o0_st, 32'd2);
    step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    chk("reseed.no_err", o0_err, 32'd0);
    chk("run.check_count", o0_cc, 32'd10);
    chk("sat.check_count", o1_cc, 32'd7);

    // Fault: Q forced low while JK=10 should drive it high.
    step(1'b1, 1'b0);
    force_q0 = 1'b1;
    step(1'b1, 1'b0);
    chk("fault.err_pulse", o0_pulse, 32'd1);
    chk("fault.err", o0_err, 32'd1);
    chk("fault.err_count", o0_ec, 32'd1);
    chk("fault.state", o0_st, 32'd3);
    chk("fault.first_err_idx", o0_fe, 32'd11);
    chk("fault.sat_first_idx", o1_fe, 32'd7);
    force_q0 = 1'b0;
    step(1'b0, 1'b0);
    chk("fault.pulse_drop", o0_pulse, 32'd0);
    chk("fault.frozen_count", o0_cc, 32'd12);
    step(1'b0, 1'b0);
    chk("fault.still_fail", o0_st, 32'd3);

    // Reset mid-run clears FAIL and sticky state immediately.
    rst = 1'b1;
    #1;
    chk("midrst.state", o0_st, 32'd0);
    chk("midrst.err", o0_err, 32'd0);
    chk("midrst.err_count", o0_ec, 32'd0);
    chk("midrst.mode_seen", o0_ms, 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;

    // Q_bar stuck low with Q low for 3 checks, after one clean check.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    qb_stuck = 1'b1;
    step(1'b0, 1'b0);
    chk("qb.first_pulse", o1_pulse, 32'd1);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    chk("qb.pulse_held", o1_pulse, 32'd1);
    qb_stuck = 1'b0;
    step(1'b0, 1'b0);
    chk("qb.pulse_drop", o1_pulse, 32'd0);
    step(1'b0, 1'b0);
    chk("qb.err_count", o1_ec, 32'd3);
    chk("qb.first_err_idx", o1_fe, 32'd1);
    chk("qb.state", o1_st, 32'd2);
    chk("qb.check_count", o1_cc, 32'd6);
    chk("qb.err", o1_err, 32'd1);
    chk("qb.u0_state", o0_st, 32'd3);
    chk("qb.u0_err_count", o0_ec, 32'd1);
    chk("qb.u0_check_count", o0_cc, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
